// File: rtl/dff_pkg.sv
// Shared defaults for the resettable register stage.
package dff_pkg;

  localparam int unsigned DFF_DEFAULT_WIDTH = 1;

endpackage

// File: rtl/dff.sv
// Positive-edge register with asynchronous active-low reset.
// Width and reset value are set per instance.
module dff
  import dff_pkg::*;
#(
  parameter int unsigned      WIDTH       = DFF_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic [WIDTH-1:0] d,
  input  logic             reset,
  input  logic             clk,
  output logic [WIDTH-1:0] q
);

  // Reset branch first so a low reset overrides any coincident clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= RESET_VALUE;
    end else begin
      q <= d;
    end
  end

endmodule

// File: tb/tb_dff.sv
// Self-checking bench for dff: a 1-bit instance and an 8-bit instance with reset value 8'hA5.
module tb_dff;

  logic       clk = 1'b0;
  logic       reset1;
  logic       d1;
  logic       q1;
  logic       reset8;
  logic [7:0] d8;
  logic [7:0] q8;

  int tests_run    = 0;
  int tests_failed = 0;

  // Scoreboards: value expected on q after the next rising edge.
  logic       sb1[$];
  logic [7:0] sb8[$];

  always #5 clk = ~clk;

  dff #(.WIDTH(1), .RESET_VALUE(1'b0)) u_dff1 (
    .d(d1), .reset(reset1), .clk(clk), .q(q1)
  );

  dff #(.WIDTH(8), .RESET_VALUE(8'hA5)) u_dff8 (
    .d(d8), .reset(reset8), .clk(clk), .q(q8)
  );

  task automatic test_reset;
    tests_run++;
    if (q1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_q1: got %b want 0", q1);
    end
    tests_run++;
    if (q8 !== 8'hA5) begin
      tests_failed++;
      $display("FAIL reset_q8: got %h want a5", q8);
    end
  endtask

  task automatic test_hold_reset;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      d1 = ~d1;
      d8 = ~d8;
      @(posedge clk);
      #1;
      tests_run++;
      if (q1 !== 1'b0) begin
        tests_failed++;
        $display("FAIL hold_reset_edge %0d: got %b want 0", i, q1);
      end
      tests_run++;
      if (q8 !== 8'hA5) begin
        tests_failed++;
        $display("FAIL hold_reset_q8 %0d: got %h want a5", i, q8);
      end
      #3;
      tests_run++;
      if (q1 !== 1'b0) begin
        tests_failed++;
        $display("FAIL hold_reset_mid %0d: got %b want 0", i, q1);
      end
    end
  endtask

  task automatic test_basic_capture;
    logic vals [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic exp;
    // Release mid-cycle; q must keep the reset value until the next edge.
    @(negedge clk);
    reset1 = 1'b1;
    d1     = 1'b0;
    sb1.push_back(1'b0);
    #1;
    tests_run++;
    if (q1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL release_hold: got %b want 0", q1);
    end
    for (int i = 0; i < 7; i++) begin
      if (i > 0) begin
        @(negedge clk);
        d1 = vals[i-1];
        sb1.push_back(vals[i-1]);
      end
      @(posedge clk);
      #1;
      tests_run++;
      if (sb1.size() == 0) begin
        tests_failed++;
        $display("FAIL capture %0d: scoreboard empty, q=%b", i, q1);
      end else begin
        exp = sb1.pop_front();
        if (q1 !== exp) begin
          tests_failed++;
          $display("FAIL capture %0d: got %b want %b", i, q1, exp);
        end
      end
    end
  endtask

  task automatic test_async_mid_cycle;
    logic exp;
    @(negedge clk);
    d1 = 1'b1;
    sb1.push_back(1'b1);
    @(posedge clk);
    #1;
    tests_run++;
    exp = (sb1.size() != 0) ? sb1.pop_front() : 1'bx;
    if (q1 !== exp) begin
      tests_failed++;
      $display("FAIL async_pre: got %b want %b", q1, exp);
    end
    #6;
    reset1 = 1'b0;
    #1;
    tests_run++;
    if (q1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_assert: got %b want 0", q1);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (q1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_edge_in_reset: got %b want 0", q1);
    end
    #1;
    reset1 = 1'b1;
    #1;
    tests_run++;
    if (q1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_release_hold: got %b want 0", q1);
    end
    sb1.push_back(1'b1);
    @(posedge clk);
    #1;
    tests_run++;
    exp = (sb1.size() != 0) ? sb1.pop_front() : 1'bx;
    if (q1 !== exp) begin
      tests_failed++;
      $display("FAIL async_first_capture: got %b want %b", q1, exp);
    end
  endtask

  task automatic test_same_step_d;
    logic exp;
    @(negedge clk);
    d1 = 1'b1;
    sb1.push_back(1'b1);
    // Nonblocking so the change lands in the same time step as the edge, after sampling.
    @(posedge clk);
    d1 <= 1'b0;
    sb1.push_back(1'b0);
    #1;
    tests_run++;
    exp = (sb1.size() != 0) ? sb1.pop_front() : 1'bx;
    if (q1 !== exp) begin
      tests_failed++;
      $display("FAIL same_step_old_d: got %b want %b", q1, exp);
    end
    @(posedge clk);
    #1;
    tests_run++;
    exp = (sb1.size() != 0) ? sb1.pop_front() : 1'bx;
    if (q1 !== exp) begin
      tests_failed++;
      $display("FAIL same_step_new_d: got %b want %b", q1, exp);
    end
  endtask

  task automatic test_reset_on_edge;
    logic exp;
    @(negedge clk);
    d1 = 1'b1;
    sb1.push_back(1'b1);
    @(posedge clk);
    #1;
    tests_run++;
    exp = (sb1.size() != 0) ? sb1.pop_front() : 1'bx;
    if (q1 !== exp) begin
      tests_failed++;
      $display("FAIL edge_reset_pre: got %b want %b", q1, exp);
    end
    @(posedge clk);
    reset1 = 1'b0;
    #1;
    tests_run++;
    if (q1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_fall_on_edge: got %b want 0", q1);
    end
    // Release in the edge's time step: that edge must not capture.
    @(posedge clk);
    reset1 <= 1'b1;
    #1;
    tests_run++;
    if (q1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_rise_on_edge: got %b want 0", q1);
    end
    sb1.push_back(1'b1);
    @(posedge clk);
    #1;
    tests_run++;
    exp = (sb1.size() != 0) ? sb1.pop_front() : 1'bx;
    if (q1 !== exp) begin
      tests_failed++;
      $display("FAIL reset_rise_next_capture: got %b want %b", q1, exp);
    end
  endtask

  task automatic test_param_8bit;
    logic [7:0] exp;
    @(negedge clk);
    reset8 = 1'b1;
    d8     = 8'h3C;
    sb8.push_back(8'h3C);
    #1;
    tests_run++;
    if (q8 !== 8'hA5) begin
      tests_failed++;
      $display("FAIL w8_release_hold: got %h want a5", q8);
    end
    @(posedge clk);
    #1;
    tests_run++;
    exp = (sb8.size() != 0) ? sb8.pop_front() : 8'hxx;
    if (q8 !== exp) begin
      tests_failed++;
      $display("FAIL w8_capture: got %h want %h", q8, exp);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp8;
    logic       exp1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      d8 = 8'($urandom_range(0, 255));
      d1 = 1'($urandom_range(0, 1));
      sb8.push_back(d8);
      sb1.push_back(d1);
      @(posedge clk);
      #1;
      tests_run++;
      exp8 = (sb8.size() != 0) ? sb8.pop_front() : 8'hxx;
      if (q8 !== exp8) begin
        tests_failed++;
        $display("FAIL b2b_q8 %0d: got %h want %h", i, q8, exp8);
      end
      tests_run++;
      exp1 = (sb1.size() != 0) ? sb1.pop_front() : 1'bx;
      if (q1 !== exp1) begin
        tests_failed++;
        $display("FAIL b2b_q1 %0d: got %b want %b", i, q1, exp1);
      end
    end
    // Mid-cycle reassert on the wide instance.
    d8 = 8'h00;
    #3;
    reset8 = 1'b0;
    #1;
    tests_run++;
    if (q8 !== 8'hA5) begin
      tests_failed++;
      $display("FAIL w8_reassert: got %h want a5", q8);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    reset1 = 1'b1;
    reset8 = 1'b1;
    d1     = 1'b0;
    d8     = 8'h00;
    #1;
    reset1 = 1'b0;
    reset8 = 1'b0;
    #1;
    test_reset();
    test_hold_reset();
    test_basic_capture();
    test_async_mid_cycle();
    test_same_step_d();
    test_reset_on_edge();
    test_param_8bit();
    test_back_to_back();
    tests_run++;
    if (sb1.size() != 0 || sb8.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: left %0d/%0d want 0/0", sb1.size(), sb8.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
